// File: rtl/demux_1x2_stream_router.sv
// Buffered valid/ready 1-to-2 demultiplexer: each input beat is steered by sel
// into one of two first-word-fall-through FIFOs that drain independently.
module demux_1x2_stream_router #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] I,
    input  logic              sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] y0,
    output logic              y0_valid,
    input  logic              y0_ready,
    output logic [DATA_W-1:0] y1,
    output logic              y1_valid,
    input  logic              y1_ready,
    output logic [CNT_W-1:0]  y0_count,
    output logic [CNT_W-1:0]  y1_count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    logic [PTR_W-1:0] wr_ptr0;
    logic [PTR_W-1:0] rd_ptr0;
    logic [PTR_W-1:0] wr_ptr1;
    logic [PTR_W-1:0] rd_ptr1;

    logic full0;
    logic full1;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic             push,
        input logic             pop
    );
        logic [CNT_W-1:0] res;
        case ({push, pop})
            2'b10:   res = cnt + CNT_W'(1);
            2'b01:   res = cnt - CNT_W'(1);
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Acceptance looks only at the targeted FIFO's fullness; a pop in the same
    // cycle does not free a slot until the following cycle.
    assign full0    = (y0_count == FULL_CNT);
    assign full1    = (y1_count == FULL_CNT);
    assign in_ready = !rst && (sel ? !full1 : !full0);

    assign push0 = in_valid && in_ready && !sel;
    assign push1 = in_valid && in_ready && sel;
    assign pop0  = !rst && y0_valid && y0_ready;
    assign pop1  = !rst && y1_valid && y1_ready;

    assign y0_valid = (y0_count != '0);
    assign y1_valid = (y1_count != '0);
    assign y0       = y0_valid ? mem0[rd_ptr0] : '0;
    assign y1       = y1_valid ? mem1[rd_ptr1] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr0  <= '0;
            rd_ptr0  <= '0;
            y0_count <= '0;
            wr_ptr1  <= '0;
            rd_ptr1  <= '0;
            y1_count <= '0;
        end else begin
            if (push0) wr_ptr0 <= PTR_W'(wr_ptr0 + 1'b1);
            if (pop0)  rd_ptr0 <= PTR_W'(rd_ptr0 + 1'b1);
            if (push1) wr_ptr1 <= PTR_W'(wr_ptr1 + 1'b1);
            if (pop1)  rd_ptr1 <= PTR_W'(rd_ptr1 + 1'b1);
            y0_count <= next_count(y0_count, push0, pop0);
            y1_count <= next_count(y1_count, push1, pop1);
        end
    end

    // Storage carries no reset; stale entries are masked by the counts.
    always_ff @(posedge clk) begin
        if (push0) mem0[wr_ptr0] <= I;
        if (push1) mem1[wr_ptr1] <= I;
    end

endmodule

// File: tb/tb_demux_1x2_stream_router.sv
// Self-checking bench: directed scenarios plus random traffic compared each
// cycle against a queue-based reference of the two output FIFOs.
module tb_demux_1x2_stream_router;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] I;
    logic              sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] y0;
    logic              y0_valid;
    logic              y0_ready;
    logic [DATA_W-1:0] y1;
    logic              y1_valid;
    logic              y1_ready;
    logic [CNT_W-1:0]  y0_count;
    logic [CNT_W-1:0]  y1_count;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] q0 [$];
    logic [DATA_W-1:0] q1 [$];

    demux_1x2_stream_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .I        (I),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y1       (y1),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .y0_count (y0_count),
        .y1_count (y1_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the reference before
    // the edge, then advance the reference by what the edge should do.
    task automatic step(input logic r, input logic v, input logic s,
                        input logic [DATA_W-1:0] d, input logic r0, input logic r1);
        bit exp_rdy, do_push, do_pop0, do_pop1;
        @(negedge clk);
        rst = r; in_valid = v; sel = s; I = d; y0_ready = r0; y1_ready = r1;
        #1;
        exp_rdy = !r && ((s ? q1.size() : q0.size()) < DEPTH);
        check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_val("y0_valid", 32'(y0_valid), 32'(q0.size() != 0));
        check_val("y1_valid", 32'(y1_valid), 32'(q1.size() != 0));
        check_val("y0_count", 32'(y0_count), 32'(q0.size()));
        check_val("y1_count", 32'(y1_count), 32'(q1.size()));
        check_val("y0_data", 32'(y0), (q0.size() != 0) ? 32'(q0[0]) : 32'h0);
        check_val("y1_data", 32'(y1), (q1.size() != 0) ? 32'(q1[0]) : 32'h0);
        do_push = v && exp_rdy;
        do_pop0 = !r && r0 && (q0.size() != 0);
        do_pop1 = !r && r1 && (q1.size() != 0);
        @(posedge clk);
        if (r) begin
            q0.delete();
            q1.delete();
        end else begin
            if (do_pop0) void'(q0.pop_front());
            if (do_pop1) void'(q1.pop_front());
            if (do_push) begin
                if (s) q1.push_back(d);
                else   q0.push_back(d);
            end
        end
    endtask

    task automatic idle(input int n, input logic r0, input logic r1);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'h00, r0, r1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sel = 1'b0; I = '0; y0_ready = 1'b0; y1_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset then idle, in_ready for either sel
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Alternating routing
        step(1'b0, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'hB2, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);

        // Fill FIFO 0 and block; y1 still accepts
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + k), 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);

        // Full with concurrent pop: push refused, then accepted next cycle
        step(1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        idle(6, 1'b1, 1'b1);

        // Wrap-around through FIFO 0
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + k), 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);

        // Mid-operation reset with both FIFOs holding three beats
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'(k % 2), 8'(8'h30 + k), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b1);

        // Random traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            step(1'(($urandom % 60) == 0), 1'($urandom % 4 != 0), 1'($urandom),
                 8'($urandom), 1'($urandom % 3 == 0), 1'($urandom % 2));
        end
        idle(6, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
